// File: rtl/uart_word_bridge.sv
// uart_word_bridge: packs bytes popped from the UART receive FIFO into
// little-endian words, and unpacks words into bytes for the UART transmit
// FIFO. The receive and transmit paths share nothing but the clock and reset.
module uart_word_bridge #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 50000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_empty,
  input  logic [7:0]        i_r_data,
  output logic              o_rd_uart,
  input  logic              i_tx_full,
  output logic              o_wr_uart,
  output logic [7:0]        o_w_data,
  output logic [DATA_W-1:0] o_rx_word,
  output logic              o_rx_valid,
  output logic              o_rx_err,
  input  logic [DATA_W-1:0] i_tx_word,
  input  logic              i_tx_valid,
  output logic              o_tx_ready
);

  localparam int NB = DATA_W / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic {RX_IDLE, RX_POP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t;

  rx_state_t           rx_state, rx_state_n;
  logic [IW-1:0]       rx_idx, rx_idx_n;
  logic [DATA_W-1:0]   rx_buf, rx_buf_n;
  logic [TW-1:0]       rx_cnt, rx_cnt_n;
  logic [DATA_W-1:0]   rx_word_n;
  logic                rd_n, rx_valid_n, rx_err_n;

  tx_state_t           tx_state, tx_state_n;
  logic [IW-1:0]       tx_idx, tx_idx_n;
  logic [DATA_W-1:0]   tx_buf, tx_buf_n;
  logic                wr_n;
  logic [7:0]          w_data_n;

  // RX next state: capture a byte per pop, publish the word on the last lane,
  // and drop a stale partial word once the inactivity counter expires
  always_comb begin
    rx_state_n = rx_state;
    rx_idx_n   = rx_idx;
    rx_buf_n   = rx_buf;
    rx_cnt_n   = rx_cnt;
    rx_word_n  = o_rx_word;
    rd_n       = 1'b0;
    rx_valid_n = 1'b0;
    rx_err_n   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!i_rx_empty) begin
          rx_buf_n[8*int'(rx_idx) +: 8] = i_r_data;
          rd_n       = 1'b1;
          rx_cnt_n   = '0;
          rx_state_n = RX_POP;
          if (rx_idx == LAST_IDX) begin
            rx_word_n  = rx_buf_n;
            rx_valid_n = 1'b1;
            rx_idx_n   = '0;
          end else begin
            rx_idx_n = rx_idx + 1'b1;
          end
        end else if ((TIMEOUT > 0) && (rx_idx != '0)) begin
          if (rx_cnt == TW'(TIMEOUT - 1)) begin
            rx_cnt_n = '0;
            rx_idx_n = '0;
            rx_err_n = 1'b1;
          end else begin
            rx_cnt_n = rx_cnt + 1'b1;
          end
        end
      end
      RX_POP:  rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX state and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_state   <= RX_IDLE;
      rx_idx     <= '0;
      rx_buf     <= '0;
      rx_cnt     <= '0;
      o_rx_word  <= '0;
      o_rd_uart  <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_err   <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_idx     <= rx_idx_n;
      rx_buf     <= rx_buf_n;
      rx_cnt     <= rx_cnt_n;
      o_rx_word  <= rx_word_n;
      o_rd_uart  <= rd_n;
      o_rx_valid <= rx_valid_n;
      o_rx_err   <= rx_err_n;
    end
  end

  // TX next state: latch a word, then push one byte per SEND/GAP pair,
  // waiting in SEND while the transmit FIFO is full
  always_comb begin
    tx_state_n = tx_state;
    tx_idx_n   = tx_idx;
    tx_buf_n   = tx_buf;
    wr_n       = 1'b0;
    w_data_n   = o_w_data;
    case (tx_state)
      TX_IDLE: begin
        if (i_tx_valid) begin
          tx_buf_n   = i_tx_word;
          tx_idx_n   = '0;
          tx_state_n = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!i_tx_full) begin
          wr_n       = 1'b1;
          w_data_n   = tx_buf[8*int'(tx_idx) +: 8];
          tx_state_n = TX_GAP;
        end
      end
      TX_GAP: begin
        if (tx_idx == LAST_IDX) begin
          tx_state_n = TX_IDLE;
        end else begin
          tx_idx_n   = tx_idx + 1'b1;
          tx_state_n = TX_SEND;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // TX state and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tx_state  <= TX_IDLE;
      tx_idx    <= '0;
      tx_buf    <= '0;
      o_wr_uart <= 1'b0;
      o_w_data  <= '0;
    end else begin
      tx_state  <= tx_state_n;
      tx_idx    <= tx_idx_n;
      tx_buf    <= tx_buf_n;
      o_wr_uart <= wr_n;
      o_w_data  <= w_data_n;
    end
  end

  assign o_tx_ready = (tx_state == TX_IDLE);

endmodule

// File: tb/tb_uart_word_bridge.sv
// tb_uart_word_bridge: directed stimulus with a queue-based scoreboard.
// Stimulus pushes expected words/bytes/errors; a negedge monitor checks them
// whenever the bridge presents a word, a byte or an error pulse.
module tb_uart_word_bridge;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 20;

  logic              i_clk      = 1'b0;
  logic              i_reset    = 1'b0;
  logic              i_rx_empty = 1'b1;
  logic [7:0]        i_r_data   = 8'h00;
  logic              i_tx_full  = 1'b0;
  logic [DATA_W-1:0] i_tx_word  = '0;
  logic              i_tx_valid = 1'b0;
  logic              o_rd_uart, o_wr_uart, o_rx_valid, o_rx_err, o_tx_ready;
  logic [7:0]        o_w_data;
  logic [DATA_W-1:0] o_rx_word;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  int exp_err    = 0;
  logic full_q   = 1'b0;

  logic [7:0]        rx_fifo[$];
  logic [DATA_W-1:0] exp_rx[$];
  logic [7:0]        exp_tx[$];
  int rd_cycles[$], valid_cycles[$], wr_cycles[$], err_cycles[$];

  uart_word_bridge #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rx_empty(i_rx_empty), .i_r_data(i_r_data), .o_rd_uart(o_rd_uart),
    .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart), .o_w_data(o_w_data),
    .o_rx_word(o_rx_word), .o_rx_valid(o_rx_valid), .o_rx_err(o_rx_err),
    .i_tx_word(i_tx_word), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready)
  );

  // 100 MHz clock
  always #5 i_clk = ~i_clk;

  // Cycle counter and the transmit-full flag as the bridge saw it last edge
  always @(posedge i_clk) begin
    cyc    <= cyc + 1;
    full_q <= i_tx_full;
  end

  // Receive FIFO model: pop on the edge that ends a pop cycle
  always @(posedge i_clk) begin
    if (o_rd_uart && rx_fifo.size() > 0) void'(rx_fifo.pop_front());
  end

  // Receive FIFO model: present empty flag and head byte
  always @(negedge i_clk) begin
    i_rx_empty = (rx_fifo.size() == 0);
    i_r_data   = (rx_fifo.size() > 0) ? rx_fifo[0] : 8'h00;
  end

  function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endfunction

  // Scoreboard monitor
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_rd_uart) begin
        rd_cycles.push_back(cyc);
        checkOutput("rd_while_empty", 32'(rx_fifo.size() > 0), 1);
      end
      if (o_rx_valid) begin
        valid_cycles.push_back(cyc);
        if (exp_rx.size() == 0) checkOutput("rx_valid_unexpected", 32'(o_rx_valid), 0);
        else checkOutput("rx_word", o_rx_word, exp_rx.pop_front());
      end
      if (o_wr_uart) begin
        wr_cycles.push_back(cyc);
        checkOutput("wr_while_full", 32'(full_q), 0);
        if (exp_tx.size() == 0) checkOutput("tx_push_unexpected", 32'(o_wr_uart), 0);
        else checkOutput("tx_byte", 32'(o_w_data), 32'(exp_tx.pop_front()));
      end
      if (o_rx_err) begin
        err_cycles.push_back(cyc);
        if (exp_err > 0) begin
          exp_err--;
          checkOutput("rx_err_pulse", 32'(o_rx_err), 1);
        end else begin
          checkOutput("rx_err_unexpected", 32'(o_rx_err), 0);
        end
      end
    end
  end

  // Global watchdog
  initial begin
    repeat (20000) @(posedge i_clk);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge i_clk);
  endtask

  // Queue a word's bytes (LSB first) in the receive FIFO and expect the word
  task automatic applyStimulus(input logic [DATA_W-1:0] w);
    for (int k = 0; k < DATA_W / 8; k++) rx_fifo.push_back(w[8*k +: 8]);
    exp_rx.push_back(w);
  endtask

  // Offer a word on the transmit side; returns the handshake cycle
  task automatic send_tx(input logic [DATA_W-1:0] w, input bit keep_valid, output int t_hs);
    bit done = 0;
    i_tx_word  = w;
    i_tx_valid = 1'b1;
    t_hs = -1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge i_clk);
      if (o_tx_ready) begin
        done = 1;
        t_hs = cyc;
      end
    end
    if (!done) checkOutput("tx_handshake_timeout", 32'(o_tx_ready), 1);
    for (int k = 0; k < DATA_W / 8; k++) exp_tx.push_back(w[8*k +: 8]);
    #1;
    if (!keep_valid) i_tx_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    checkOutput({tag, "_rd_uart"},  32'(o_rd_uart), 0);
    checkOutput({tag, "_wr_uart"},  32'(o_wr_uart), 0);
    checkOutput({tag, "_w_data"},   32'(o_w_data), 0);
    checkOutput({tag, "_rx_word"},  o_rx_word, 0);
    checkOutput({tag, "_rx_valid"}, 32'(o_rx_valid), 0);
    checkOutput({tag, "_rx_err"},   32'(o_rx_err), 0);
    checkOutput({tag, "_tx_ready"}, 32'(o_tx_ready), 1);
  endtask

  initial begin
    int t, t1, t2, th;

    // Reset
    #1 i_reset = 1'b1;
    #1 check_reset("reset");
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;

    // RX assembly: 78 56 34 12 back-to-back
    next_cycle();
    rd_cycles.delete(); valid_cycles.delete();
    t = cyc;
    applyStimulus(32'h12345678);
    wait_until(t + 12);
    checkOutput("rx_pop_count", rd_cycles.size(), 4);
    if (rd_cycles.size() == 4)
      for (int k = 0; k < 4; k++) checkOutput("rx_pop_cycle", rd_cycles[k], t + 1 + 2*k);
    checkOutput("rx_valid_count", valid_cycles.size(), 1);
    if (valid_cycles.size() == 1) checkOutput("rx_valid_cycle", valid_cycles[0], t + 7);
    checkOutput("rx_word_held", o_rx_word, 32'h12345678);

    // TX serialization: DEADBEEF with no backpressure
    next_cycle();
    wr_cycles.delete();
    send_tx(32'hDEADBEEF, 1'b0, t);
    wait_until(t + 8);
    checkOutput("tx_ready_busy", 32'(o_tx_ready), 0);
    wait_until(t + 9);
    checkOutput("tx_ready_back", 32'(o_tx_ready), 1);
    checkOutput("tx_push_count", wr_cycles.size(), 4);
    if (wr_cycles.size() == 4)
      for (int k = 0; k < 4; k++) checkOutput("tx_push_cycle", wr_cycles[k], t + 2 + 2*k);

    // TX backpressure: full for 10 cycles after the second byte
    next_cycle();
    wr_cycles.delete();
    send_tx(32'hCAFEBABE, 1'b0, t);
    wait_until(t + 3);
    next_cycle();
    i_tx_full = 1'b1;
    wait_until(t + 13);
    next_cycle();
    i_tx_full = 1'b0;
    wait_until(t + 17);
    checkOutput("bp_ready_busy", 32'(o_tx_ready), 0);
    wait_until(t + 18);
    checkOutput("bp_ready_back", 32'(o_tx_ready), 1);
    checkOutput("bp_push_count", wr_cycles.size(), 4);
    if (wr_cycles.size() == 4) begin
      checkOutput("bp_push_cycle0", wr_cycles[0], t + 2);
      checkOutput("bp_push_cycle1", wr_cycles[1], t + 4);
      checkOutput("bp_push_cycle2", wr_cycles[2], t + 15);
      checkOutput("bp_push_cycle3", wr_cycles[3], t + 17);
    end

    // RX timeout: two bytes then silence
    next_cycle();
    err_cycles.delete();
    t = cyc;
    rx_fifo.push_back(8'hAA);
    rx_fifo.push_back(8'hBB);
    exp_err = 1;
    wait_until(t + 40);
    checkOutput("rx_err_count", err_cycles.size(), 1);
    if (err_cycles.size() == 1)
      checkOutput("rx_err_window", 32'(err_cycles[0] >= t + 20 && err_cycles[0] <= t + 26), 1);
    checkOutput("rx_word_kept", o_rx_word, 32'h12345678);
    next_cycle();
    applyStimulus(32'h04030201);
    wait_until(cyc + 12);
    checkOutput("rx_after_timeout", o_rx_word, 32'h04030201);

    // Reset in the middle of an RX word and a TX word
    next_cycle();
    t = cyc;
    rx_fifo.push_back(8'h99);
    rx_fifo.push_back(8'h88);
    send_tx(32'h0BADF00D, 1'b0, th);
    checkOutput("mid_handshake_cycle", th, t);
    wait_until(t + 4);
    next_cycle();
    i_reset = 1'b1;
    #1 check_reset("midreset");
    checkOutput("mid_tx_bytes_left", exp_tx.size(), 2);
    exp_tx.delete();
    rx_fifo.delete();
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    next_cycle();
    applyStimulus(32'h44332211);
    wait_until(cyc + 12);
    checkOutput("rx_after_reset", o_rx_word, 32'h44332211);

    // Full duplex: continuous RX stream and back-to-back TX words
    next_cycle();
    valid_cycles.delete(); wr_cycles.delete();
    t = cyc;
    applyStimulus(32'hA1B2C3D4);
    applyStimulus(32'h0F1E2D3C);
    applyStimulus(32'h89ABCDEF);
    send_tx(32'h01234567, 1'b1, th);
    send_tx(32'h76543210, 1'b1, t1);
    send_tx(32'h5A5AA5A5, 1'b0, t2);
    checkOutput("fd_hs0", th, t);
    checkOutput("fd_hs1", t1, t + 9);
    checkOutput("fd_hs2", t2, t + 18);
    wait_until(t + 30);
    checkOutput("fd_rx_words", valid_cycles.size(), 3);
    if (valid_cycles.size() == 3) checkOutput("fd_rx_last", valid_cycles[2], t + 23);
    checkOutput("fd_tx_bytes", wr_cycles.size(), 12);
    if (wr_cycles.size() == 12) checkOutput("fd_tx_last", wr_cycles[11], t + 26);

    // Everything expected must have been seen
    wait_until(cyc + 4);
    checkOutput("left_rx_words", exp_rx.size(), 0);
    checkOutput("left_tx_bytes", exp_tx.size(), 0);
    checkOutput("left_rx_errs", exp_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
